sistema_pio_input: RTL and testbench
====================================

# sistema_pio_input

Parametrised, debounced input PIO with per-bit edge interrupts, on the Avalon-MM bus as an `s1` slave in the `sistema` system. It is the successor to the fixed 4-bit button PIO and adds the following:
- configurable width;
- a synchroniser and per-channel debounce counter;
- runtime-selectable rising/falling edge detection per bit;
- write-1-to-clear edge capture.

The interrupt output goes to the Nios II IRQ input.

## Interface
- `WIDTH`, default 4: number of input channels, 1..32.
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable cycles required before the debounced state changes. 0 bypasses debounce.
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: one clock; reset is synchronous and active-high.
- `address`  in  3: register select.
- `chipselect`  in  1: slave select.
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data. Bits `[WIDTH-1:0]` are used.
- `in_port`  in  WIDTH: raw asynchronous pins.
- `readdata`  out  32: registered read data. Reset value 0.
- `irq`  out  1: level interrupt. Reset value 0.

## Operation
Register map (all unused upper bits read as 0):
- 0 DATA (RO): debounced state `db`.
- 1 RAW (RO): synchronised raw input `s2`.
- 2 IRQ_MASK (RW).
- 3 EDGE_CAPTURE (RW1C).
- 4 RISE_EN (RW).
- 5 FALL_EN (RW).
- 6–7 read 0 and ignore writes.

Write behaviour:
- A write is `chipselect & ~write_n`.
- Writes to RO addresses are ignored.

Synchroniser and debounce:
- Synchroniser: `s1 <= in_port; s2 <= s1`.
- Debounce, per bit:
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: set `db <= s2`, `cnt <= 0`, and assert `upd` for that cycle.
  - Else: `cnt <= cnt+1`.
- Any bounce back to `db` before terminal count restarts the count from 0.
- Counter width is `$clog2(DEBOUNCE_CYCLES+1)`. The counter never wraps.
- With `DEBOUNCE_CYCLES == 0`: `db <= s2` every cycle, and `upd = (s2 != db)`.

Edge detection and capture, per bit:
- Events:
  - `rise = upd & s2 & RISE_EN`.
  - `fall = upd & ~s2 & FALL_EN`.
- Capture bit:
  - A write to EDGE_CAPTURE clears the bits where `writedata` is 1.
  - Bits written 0 are untouched.
  - Set on the same edge when `rise | fall`.
  - Simultaneous clear and a new event on the same bit: the set wins.

Interrupt and reads:
- `irq = |(EDGE_CAPTURE & IRQ_MASK)`, combinational from registers.
- Readdata is registered every cycle from the address mux, independent of chipselect (read latency 1).
- Reset clears `s1`, `s2`, `db`, `cnt`, all registers, `readdata` and `irq` to 0.
- A pin held at 1 through reset therefore produces a rising event after reset if RISE_EN is set.
- Reset mid-count discards the count.

## Timing
- The pin change is sampled at edge N.
- `s2` is valid after edge N+1.
- `db` updates and the capture bit sets at edge N+1+`DEBOUNCE_CYCLES`, or at edge N+2 when `DEBOUNCE_CYCLES == 0`.
- `irq` rises in the same cycle as the capture bit.
- Register writes take effect at the edge where the write is presented.
- `readdata` reflects the address presented one edge earlier, including any write at that edge.
- Write-then-read of the same address returns the new value.

## Structure
- Shared package `sistema_pio_pkg` holds:
  - address constants `PIO_ADDR_DATA`…`PIO_ADDR_FALL_EN`;
  - the counter-width function.
- One sub-module is used: `sistema_pio_debounce`. It is a single-bit debouncer with parameter `DEBOUNCE_CYCLES`, inputs `s2` and `clk`/`reset`, and outputs `db` and `upd`. The top level instantiates `WIDTH` copies with `generate`.

## Test plan
All scenarios use `WIDTH=4`, `DEBOUNCE_CYCLES=4`.
- **Reset:** after reset with `in_port=0` → `readdata=0`, `irq=0`, and all registers read 0.
- **Clean rising edge:** RISE_EN=0xF, IRQ_MASK=0x1, `in_port` 0→0x1 sampled at edge N → DATA=0x1 and EDGE_CAPTURE=0x1 at edge N+5, and `irq=1` from that cycle.
- **Bounce:** `in_port[0]` toggles 1,0,1 with 2-cycle pulses, then holds 1 → a single capture, set 4 cycles after the final stable `s2`, with no earlier DATA change.
- **Falling only:** RISE_EN=0, FALL_EN=0x2, bit 1 goes 1→0 → EDGE_CAPTURE=0x2; the preceding rise of bit 1 is not captured.
- **W1C:** EDGE_CAPTURE=0xA, write 0x8 → reads 0x2; `irq` drops only if `mask & 0x2 == 0`.
- **Simultaneous:** a write-1-to-clear of bit 0 on the same edge as a new bit-0 event → bit 0 remains 1.

Source files
------------

// File: rtl/sistema_pio_pkg.sv
// Shared definitions for the sistema PIO blocks: register addresses and
// the debounce counter sizing helper.
package sistema_pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA         = 3'd0;
    localparam logic [2:0] PIO_ADDR_RAW          = 3'd1;
    localparam logic [2:0] PIO_ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] PIO_ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] PIO_ADDR_RISE_EN      = 3'd4;
    localparam logic [2:0] PIO_ADDR_FALL_EN      = 3'd5;

    // Bits needed to hold 0..cycles; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sistema_pio_debounce.sv
// Single-bit debouncer: the output follows the synchronised input only after
// it has differed for DEBOUNCE_CYCLES consecutive cycles.
module sistema_pio_debounce
    import sistema_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic s2,
    output logic db,
    output logic upd
);

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) db <= 1'b0;
                else       db <= s2;
            end
            assign upd = (s2 != db);
        end else begin : g_count
            localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // NOTE: upd is combinational so the edge event lands on the same
            // clock edge that moves db, not one cycle later.
            assign upd = (s2 != db) && (cnt == CNT_LAST);

            always_ff @(posedge clk) begin
                if (reset) begin
                    db  <= 1'b0;
                    cnt <= '0;
                end else if (s2 == db) begin
                    cnt <= '0;
                end else if (upd) begin
                    db  <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sistema_pio_input.sv
// Debounced input PIO with per-bit rising/falling edge capture (W1C) and a
// masked level interrupt, as an Avalon-MM slave.
module sistema_pio_input
    import sistema_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1, s2, db, upd;
    logic [WIDTH-1:0] irq_mask, edge_cap, rise_en, fall_en;
    logic [WIDTH-1:0] irq_mask_n, edge_cap_n, rise_en_n, fall_en_n;
    logic [WIDTH-1:0] db_n, events, wdata;
    logic [31:0]      readdata_n;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_db
            sistema_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk   (clk),
                .reset (reset),
                .s2    (s2[i]),
                .db    (db[i]),
                .upd   (upd[i])
            );
        end
    endgenerate

    always_comb begin
        wr_en      = chipselect & ~write_n;
        wdata      = writedata[WIDTH-1:0];
        irq_mask_n = irq_mask;
        edge_cap_n = edge_cap;
        rise_en_n  = rise_en;
        fall_en_n  = fall_en;
        db_n       = (upd & s2) | (~upd & db);
        events     = upd & ((s2 & rise_en) | (~s2 & fall_en));

        if (wr_en) begin
            case (address)
                PIO_ADDR_IRQ_MASK:     irq_mask_n = wdata;
                PIO_ADDR_EDGE_CAPTURE: edge_cap_n = edge_cap & ~wdata;
                PIO_ADDR_RISE_EN:      rise_en_n  = wdata;
                PIO_ADDR_FALL_EN:      fall_en_n  = wdata;
                default: ;
            endcase
        end
        // A new event outranks a same-cycle clear.
        edge_cap_n = edge_cap_n | events;

        // Read mux returns the post-edge state so a write is visible at once.
        readdata_n = '0;
        case (address)
            PIO_ADDR_DATA:         readdata_n[WIDTH-1:0] = db_n;
            PIO_ADDR_RAW:          readdata_n[WIDTH-1:0] = s1;
            PIO_ADDR_IRQ_MASK:     readdata_n[WIDTH-1:0] = irq_mask_n;
            PIO_ADDR_EDGE_CAPTURE: readdata_n[WIDTH-1:0] = edge_cap_n;
            PIO_ADDR_RISE_EN:      readdata_n[WIDTH-1:0] = rise_en_n;
            PIO_ADDR_FALL_EN:      readdata_n[WIDTH-1:0] = fall_en_n;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            readdata <= '0;
        end else begin
            irq_mask <= irq_mask_n;
            edge_cap <= edge_cap_n;
            rise_en  <= rise_en_n;
            fall_en  <= fall_en_n;
            readdata <= readdata_n;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_sistema_pio_input.sv
// Bench for sistema_pio_input (WIDTH=4, DEBOUNCE_CYCLES=4): a stability-window
// reference model checked every cycle, plus directed literal expectations.
module tb_sistema_pio_input;

    localparam int W  = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    sistema_pio_input #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: db flips once the last DC synchronised samples all
    // disagree with it; s2 is in_port delayed by two edges.
    logic          armed = 1'b0;
    logic [W-1:0]  m_s1, m_db, m_mask, m_cap, m_rise, m_fall;
    logic [W-1:0]  hist [DC];
    logic [31:0]   m_rd;
    logic [W-1:0]  m_s2c, m_upd, m_ev, m_clr;
    logic [W-1:0]  regs [8];

    always @(posedge clk) begin
        if (reset) begin
            armed  = 1'b1;
            m_s1   = '0; m_db = '0; m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '0;
            for (int k = 0; k < DC; k++) hist[k] = '0;
            m_rd   = '0;
        end else begin
            m_s2c = hist[0];
            for (int b = 0; b < W; b++) begin
                m_upd[b] = 1'b1;
                for (int k = 0; k < DC; k++)
                    if (hist[k][b] == m_db[b]) m_upd[b] = 1'b0;
            end
            m_ev  = m_upd & ((m_s2c & m_rise) | (~m_s2c & m_fall));
            m_clr = '0;
            if (chipselect && !write_n) begin
                if (address == 3'd2) m_mask = writedata[W-1:0];
                if (address == 3'd3) m_clr  = writedata[W-1:0];
                if (address == 3'd4) m_rise = writedata[W-1:0];
                if (address == 3'd5) m_fall = writedata[W-1:0];
            end
            m_cap = (m_cap & ~m_clr) | m_ev;
            m_db  = m_db ^ m_upd;
            for (int k = DC - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = m_s1;
            m_s1    = in_port;
            regs[0] = m_db;  regs[1] = hist[0]; regs[2] = m_mask; regs[3] = m_cap;
            regs[4] = m_rise; regs[5] = m_fall; regs[6] = '0;     regs[7] = '0;
            m_rd    = {{(32-W){1'b0}}, regs[address]};
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_readdata", readdata, m_rd);
            check("model_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        address = a;
        @(negedge clk);
        v = readdata;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            check("rst_reg", v, 32'h0);
        end

        // Clean rising edge: capture and irq at N+5
        wr(3'd4, 32'hF);
        wr(3'd2, 32'h1);
        address = 3'd3;
        in_port = 4'h1;
        repeat (5) @(negedge clk);
        check("rise_before_irq", {31'b0, irq}, 32'h0);
        check("rise_before_cap", readdata, 32'h0);
        @(negedge clk);
        check("rise_irq", {31'b0, irq}, 32'h1);
        check("rise_cap", readdata, 32'h1);
        rd(3'd0, v);
        check("rise_data", v, 32'h1);
        wr(3'd3, 32'h1);

        // Bounce: only the final stable level is accepted
        in_port = 4'h0;
        repeat (10) @(negedge clk);
        wr(3'd3, 32'hF);
        address = 3'd0;
        in_port = 4'h1; repeat (2) @(negedge clk);
        in_port = 4'h0; repeat (2) @(negedge clk);
        in_port = 4'h1;
        repeat (5) @(negedge clk);
        check("bounce_data_early", readdata, 32'h0);
        check("bounce_irq_early", {31'b0, irq}, 32'h0);
        @(negedge clk);
        check("bounce_data", readdata, 32'h1);
        check("bounce_irq", {31'b0, irq}, 32'h1);
        rd(3'd3, v);
        check("bounce_cap", v, 32'h1);
        wr(3'd3, 32'h1);

        // Falling only on bit 1
        wr(3'd4, 32'h0);
        wr(3'd5, 32'h2);
        in_port = 4'h3;
        repeat (10) @(negedge clk);
        rd(3'd3, v);
        check("fall_no_rise", v, 32'h0);
        in_port = 4'h1;
        repeat (10) @(negedge clk);
        rd(3'd3, v);
        check("fall_cap", v, 32'h2);
        check("fall_irq_masked", {31'b0, irq}, 32'h0);

        // W1C on EDGE_CAPTURE = 0xA
        wr(3'd4, 32'h8);
        in_port = 4'h9;
        repeat (10) @(negedge clk);
        rd(3'd3, v);
        check("w1c_pre", v, 32'hA);
        wr(3'd2, 32'h8);
        check("w1c_irq_set", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h8);
        check("w1c_irq_drop", {31'b0, irq}, 32'h0);
        rd(3'd3, v);
        check("w1c_post", v, 32'h2);
        wr(3'd2, 32'h2);
        check("w1c_irq_bit1", {31'b0, irq}, 32'h1);

        // Simultaneous clear and new bit-0 event: set wins
        wr(3'd2, 32'h1);
        wr(3'd3, 32'hF);
        wr(3'd4, 32'h1);
        wr(3'd5, 32'h0);
        in_port = 4'h8;
        repeat (10) @(negedge clk);
        wr(3'd3, 32'hF);
        in_port = 4'h9;
        repeat (5) @(negedge clk);
        wr(3'd3, 32'h1);
        check("simul_readdata", readdata, 32'h1);
        check("simul_irq", {31'b0, irq}, 32'h1);
        rd(3'd3, v);
        check("simul_cap", v, 32'h1);

        // Reset mid-count discards state; pin level re-acquired afterwards
        in_port = 4'h8;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_irq", {31'b0, irq}, 32'h0);
        repeat (10) @(negedge clk);
        rd(3'd0, v);
        check("rst2_data", v, 32'h8);
        rd(3'd3, v);
        check("rst2_cap", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
